// File: rtl/seq_scan_pkg.sv
// Shared types and default constants for the serial pattern scan controller.
package seq_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int              PLEN    = 4;
   localparam logic [PLEN-1:0] PATTERN = 4'b1010;

endpackage : seq_scan_pkg

// File: rtl/seq_scan_ctrl_pat_det.sv
// Serial pattern detector: keeps the last PLEN-1 bits and registers a match
// whenever those bits plus the incoming bit equal PATTERN (overlaps allowed).
module pat_det #(
   parameter int                PLEN    = seq_scan_pkg::PLEN,
   parameter logic [PLEN-1:0]   PATTERN = seq_scan_pkg::PATTERN
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic bit_in,
   output logic match
);
   import seq_scan_pkg::*;

   logic [PLEN-2:0] hist_r;
   logic [PLEN-1:0] window_s;
   logic            match_r;

   // Candidate window formed by the stored history and the bit being consumed
   always_comb begin
      window_s = {hist_r, bit_in};
   end

   // History shift and one-cycle match pulse; clear wins over consume
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_r  <= {(PLEN-1){1'b0}};
         match_r <= 1'b0;
      end else if (clr) begin
         hist_r  <= {(PLEN-1){1'b0}};
         match_r <= 1'b0;
      end else if (en) begin
         hist_r  <= window_s[PLEN-2:0];
         match_r <= (window_s == PATTERN);
      end else begin
         hist_r  <= hist_r;
         match_r <= 1'b0;
      end
   end

   assign match = match_r;

endmodule : pat_det

// File: rtl/seq_scan_ctrl.sv
// Feeds parallel words MSB-first into pat_det, counts matches per word and
// returns count / found / first-match position over a valid/ready interface.
module seq_scan_ctrl #(
   parameter int                WIDTH   = 16,
   parameter int                PLEN    = seq_scan_pkg::PLEN,
   parameter logic [PLEN-1:0]   PATTERN = seq_scan_pkg::PATTERN,
   parameter int                CW      = $clog2(WIDTH + 1),
   parameter int                PW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_chain,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_found,
   output logic [PW-1:0]    out_first,
   output logic             busy
);
   import seq_scan_pkg::*;

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_r;
   logic [WIDTH-1:0] sr_r;
   logic [CW-1:0]    bitcnt_r;
   logic [CW-1:0]    cnt_r;
   logic             found_r;
   logic [PW-1:0]    first_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [CW-1:0]    out_count_r;
   logic             out_found_r;
   logic [PW-1:0]    out_first_r;
   logic             busy_r;

   logic             accept_s;
   logic             abort_s;
   logic             det_en_s;
   logic             det_clr_s;
   logic             match_s;
   logic [CW-1:0]    cnt_next_s;
   logic             found_next_s;
   logic [PW-1:0]    first_next_s;

   // Detector sequencing: consume in SHIFT, clear on unchained accept or abort
   always_comb begin
      accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
      abort_s   = ((state_r == SHIFT) || (state_r == DRAIN)) && abort;
      det_en_s  = (state_r == SHIFT);
      det_clr_s = (accept_s && !in_chain) || abort_s;
   end

   pat_det #(
      .PLEN    (PLEN),
      .PATTERN (PATTERN)
   ) u_det (
      .clk    (clk),
      .reset  (reset),
      .en     (det_en_s),
      .clr    (det_clr_s),
      .bit_in (sr_r[WIDTH-1]),
      .match  (match_s)
   );

   // Match bookkeeping; the match seen now belongs to bit bitcnt_r-1
   always_comb begin
      cnt_next_s   = cnt_r;
      found_next_s = found_r;
      first_next_s = first_r;
      if (match_s) begin
         if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + CW'(1);
         end else begin
            cnt_next_s = cnt_r;
         end
         found_next_s = 1'b1;
         if (!found_r) begin
            first_next_s = PW'(bitcnt_r - CW'(1));
         end else begin
            first_next_s = first_r;
         end
      end else begin
         cnt_next_s   = cnt_r;
         found_next_s = found_r;
         first_next_s = first_r;
      end
   end

   // Controller FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         sr_r        <= {WIDTH{1'b0}};
         bitcnt_r    <= {CW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         found_r     <= 1'b0;
         first_r     <= {PW{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_count_r <= {CW{1'b0}};
         out_found_r <= 1'b0;
         out_first_r <= {PW{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  sr_r       <= in_data;
                  bitcnt_r   <= {CW{1'b0}};
                  cnt_r      <= {CW{1'b0}};
                  found_r    <= 1'b0;
                  first_r    <= {PW{1'b0}};
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= SHIFT;
               end else begin
                  state_r    <= IDLE;
               end
            end
            SHIFT: begin
               if (abort_s) begin
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= IDLE;
               end else begin
                  sr_r     <= {sr_r[WIDTH-2:0], 1'b0};
                  bitcnt_r <= bitcnt_r + CW'(1);
                  cnt_r    <= cnt_next_s;
                  found_r  <= found_next_s;
                  first_r  <= first_next_s;
                  if (bitcnt_r == LAST_BIT) begin
                     state_r <= DRAIN;
                  end else begin
                     state_r <= SHIFT;
                  end
               end
            end
            DRAIN: begin
               if (abort_s) begin
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= IDLE;
               end else begin
                  cnt_r   <= cnt_next_s;
                  found_r <= found_next_s;
                  first_r <= first_next_s;
                  state_r <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes; later cycles wait for the consumer
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
                  out_count_r <= cnt_r;
                  out_found_r <= found_r;
                  out_first_r <= first_r;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r     <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_count = out_count_r;
   assign out_found = out_found_r;
   assign out_first = out_first_r;
   assign busy      = busy_r;

endmodule : seq_scan_ctrl

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl with hand-computed results.
module tb_seq_scan_ctrl;

   localparam int WIDTH = 16;
   localparam int CW    = 5;
   localparam int PW    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = 16'h0000;
   logic             in_chain = 1'b0;
   logic             abort = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CW-1:0]    out_count;
   logic             out_found;
   logic [PW-1:0]    out_first;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   seq_scan_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_chain  (in_chain),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_found (out_found),
      .out_first (out_first),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present a word at a negedge; returns 1ns after the accept edge
   task automatic start_word(input logic [WIDTH-1:0] d, input logic ch);
      @(negedge clk);
      check_eq("in_ready_idle", 32'(in_ready), 32'd1);
      in_data  = d;
      in_chain = ch;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is seen (bounded)
   task automatic wait_result(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("valid_drop", 32'(out_valid), 32'd0);
      check_eq("ready_back", 32'(in_ready), 32'd1);
   endtask

   task automatic scan_word(input string tag, input logic [WIDTH-1:0] d, input logic ch,
                            input int exp_cnt, input int exp_found, input int exp_first);
      int lat;
      start_word(d, ch);
      wait_result(lat);
      check_eq({tag, "_latency"}, 32'(lat), 32'd18);
      check_eq({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
      check_eq({tag, "_found"}, 32'(out_found), 32'(exp_found));
      check_eq({tag, "_first"}, 32'(out_first), 32'(exp_first));
      handshake();
   endtask

   initial begin
      int  lat;
      logic seen;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_count", 32'(out_count), 32'd0);
      check_eq("rst_found", 32'(out_found), 32'd0);
      check_eq("rst_first", 32'(out_first), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Overlapping matches plus backpressure while DONE
      start_word(16'hAAAA, 1'b0);
      check_eq("busy_shift", 32'(busy), 32'd1);
      check_eq("ready_shift", 32'(in_ready), 32'd0);
      wait_result(lat);
      check_eq("aaaa_latency", 32'(lat), 32'd18);
      check_eq("aaaa_count", 32'(out_count), 32'd7);
      check_eq("aaaa_found", 32'(out_found), 32'd1);
      check_eq("aaaa_first", 32'(out_first), 32'd3);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0005;
      repeat (10) @(posedge clk);
      #1;
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_count", 32'(out_count), 32'd7);
      check_eq("bp_first", 32'(out_first), 32'd3);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      in_valid = 1'b0;
      handshake();
      check_eq("bp_busy_after", 32'(busy), 32'd0);

      scan_word("zero", 16'h0000, 1'b0, 0, 0, 0);

      // Chaining across a word boundary, then the same pair unchained
      scan_word("ch_a0", 16'h0005, 1'b0, 0, 0, 0);
      scan_word("ch_b0", 16'h0000, 1'b0, 0, 0, 0);
      scan_word("ch_a1", 16'h0005, 1'b0, 0, 0, 0);
      scan_word("ch_b1", 16'h0000, 1'b1, 1, 1, 0);

      // Asynchronous reset while bit 6 is in flight
      start_word(16'hAAAA, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_count", 32'(out_count), 32'd0);
      check_eq("mid_rst_found", 32'(out_found), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      scan_word("post_rst", 16'hAAAA, 1'b1, 7, 1, 3);

      // Abort while bit 9 is in flight
      start_word(16'hAAAA, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check_eq("abort_no_valid", 32'(seen), 32'd0);
      scan_word("post_abort", 16'h000A, 1'b1, 1, 1, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_seq_scan_ctrl
